// File: rtl/instr_fetch.sv
// Fetch stage and program sequencer: owns the instruction ROM address, applies
// decoder goto/skip/halt requests, and runs the start/run/done handshake.
module instr_fetch #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Ack,
    input  logic             GotoEn,
    input  logic [PC_W-1:0]  GotoTarget,
    input  logic             Jump2En,
    input  logic             BranchCond,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        cnt_nxt   = InstrCount;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = StartAddr;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                // The halt cycle still counts as an executed instruction.
                if (InstrCount != '1)
                    cnt_nxt = InstrCount + 1'b1;
                if (Ack)
                    state_nxt = S_DONE;
                else if (GotoEn)
                    pc_nxt = GotoTarget;
                else if (Jump2En && BranchCond)
                    pc_nxt = ProgCtr + PC_W'(2);
                else
                    pc_nxt = ProgCtr + PC_W'(1);
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            ProgCtr    <= '0;
            InstrCount <= '0;
        end else begin
            state      <= state_nxt;
            ProgCtr    <= pc_nxt;
            InstrCount <= cnt_nxt;
        end
    end

    assign Running = (state == S_RUN);
    assign Done    = (state == S_DONE);

endmodule
